wb_stage: RTL and testbench

- Writeback stage of LemonPC, directly upstream of the register file.
- Accepts one completed instruction at a time from execute/memory, over a valid/ready handshake.
- For loads, waits for the data memory response, then aligns and extends it.
- Drives the register file write port (rd/wen/dataD) from registers and emits a one-cycle retire pulse per instruction.

---
 rtl/wb_stage.sv | 143 ++++++++++++++
 tb/tb_wb_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: accepts one completed instruction at a time. Loads wait for
// the data memory response, then the aligned and extended value is written.
// All register file and retire outputs are registered.
module wb_stage #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [2:0]            in_addr_low,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic                  rf_wen,
  output logic [DATA_WIDTH-1:0] rf_dataD,
  output logic                  retire_valid,
  output logic [DATA_WIDTH-1:0] retire_pc
);

  // The load extraction below hard-codes byte lanes of a 64-bit doubleword.
  if (DATA_WIDTH != 64) begin : g_width_check
    $error("wb_stage: only DATA_WIDTH == 64 is supported");
  end

  typedef enum logic [0:0] {StIdle, StWaitMem} state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] rd_q;
  logic                  rd_wen_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [2:0]            funct3_q;
  logic [2:0]            addr_low_q;

  logic [ADDR_WIDTH-1:0] rf_rd_q;
  logic                  rf_wen_q;
  logic [DATA_WIDTH-1:0] rf_data_q;
  logic                  retire_valid_q;
  logic [DATA_WIDTH-1:0] retire_pc_q;

  logic                  accept;
  logic                  load_done;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_word;
  logic [DATA_WIDTH-1:0] load_data;

  assign in_ready  = (state_q == StIdle);
  assign accept    = in_valid && in_ready;
  assign load_done = (state_q == StWaitMem) && mem_rvalid;

  // Next-state logic: only loads leave IDLE; the memory response returns to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept && in_is_load) state_d = StWaitMem;
      StWaitMem: if (mem_rvalid) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Capture the instruction context needed to complete a pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= '0;
      rd_wen_q   <= 1'b0;
      pc_q       <= '0;
      funct3_q   <= 3'b000;
      addr_low_q <= 3'b000;
    end else if (accept) begin
      rd_q       <= in_rd;
      rd_wen_q   <= in_rd_wen;
      pc_q       <= in_pc;
      funct3_q   <= in_funct3;
      addr_low_q <= in_addr_low;
    end
  end

  // Select the addressed lane; address bits below the access size are ignored.
  always_comb begin
    ld_byte   = mem_rdata[{addr_low_q, 3'b000} +: 8];
    ld_half   = mem_rdata[{addr_low_q[2:1], 4'b0000} +: 16];
    ld_word   = mem_rdata[{addr_low_q[2], 5'b00000} +: 32];
    load_data = '0;
    unique case (funct3_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  load_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      3'b010:  load_data = {{(DATA_WIDTH-32){ld_word[31]}}, ld_word};
      3'b110:  load_data = {{(DATA_WIDTH-32){1'b0}}, ld_word};
      3'b011:  load_data = mem_rdata;
      default: load_data = '0;
    endcase
  end

  // Write/retire outputs: pulse for one cycle, index/data/pc hold between events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_rd_q        <= '0;
      rf_wen_q       <= 1'b0;
      rf_data_q      <= '0;
      retire_valid_q <= 1'b0;
      retire_pc_q    <= '0;
    end else if (accept && !in_is_load) begin
      rf_rd_q        <= in_rd;
      rf_wen_q       <= in_rd_wen && (in_rd != '0);
      rf_data_q      <= in_result;
      retire_valid_q <= 1'b1;
      retire_pc_q    <= in_pc;
    end else if (load_done) begin
      rf_rd_q        <= rd_q;
      rf_wen_q       <= rd_wen_q && (rd_q != '0);
      rf_data_q      <= load_data;
      retire_valid_q <= 1'b1;
      retire_pc_q    <= pc_q;
    end else begin
      rf_wen_q       <= 1'b0;
      retire_valid_q <= 1'b0;
    end
  end

  assign rf_rd        = rf_rd_q;
  assign rf_wen       = rf_wen_q;
  assign rf_dataD     = rf_data_q;
  assign retire_valid = retire_valid_q;
  assign retire_pc    = retire_pc_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed testbench for wb_stage. Inputs are driven and outputs sampled 1ns
// after each rising clock edge.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [4:0]  in_rd;
  logic        in_rd_wen;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [2:0]  in_addr_low;
  logic [63:0] in_result;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic [4:0]  rf_rd;
  logic        rf_wen;
  logic [63:0] rf_dataD;
  logic        retire_valid;
  logic [63:0] retire_pc;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_stage #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_rd        (in_rd),
    .in_rd_wen    (in_rd_wen),
    .in_is_load   (in_is_load),
    .in_funct3    (in_funct3),
    .in_addr_low  (in_addr_low),
    .in_result    (in_result),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_rd        (rf_rd),
    .rf_wen       (rf_wen),
    .rf_dataD     (rf_dataD),
    .retire_valid (retire_valid),
    .retire_pc    (retire_pc)
  );

  // {in_ready, rf_wen, retire_valid, rf_rd, rf_dataD, retire_pc}
  logic [135:0] obs;
  assign obs = {in_ready, rf_wen, retire_valid, rf_rd, rf_dataD, retire_pc};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid    = 1'b0;
    in_pc       = '0;
    in_rd       = '0;
    in_rd_wen   = 1'b0;
    in_is_load  = 1'b0;
    in_funct3   = 3'b000;
    in_addr_low = 3'b000;
    in_result   = '0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic test_reset();
    logic [135:0] exp;
    rst_n       = 1'b0;
    in_valid    = 1'($urandom);
    in_pc       = {$urandom, $urandom};
    in_rd       = 5'($urandom);
    in_rd_wen   = 1'($urandom);
    in_is_load  = 1'($urandom);
    in_funct3   = 3'($urandom);
    in_addr_low = 3'($urandom);
    in_result   = {$urandom, $urandom};
    mem_rvalid  = 1'($urandom);
    mem_rdata   = {$urandom, $urandom};
    repeat (3) tick();
    exp = {1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", obs, exp);
    end
    clear_inputs();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [135:0] exp;
    in_valid  = 1'b1;
    in_rd_wen = 1'b1;
    in_pc     = 64'h8000_0000;
    in_rd     = 5'd5;
    in_result = 64'h1234;
    tick();
    in_pc     = 64'h8000_0004;
    in_rd     = 5'd6;
    in_result = 64'hFFFF_FFFF_FFFF_FFFF;
    exp = {1'b1, 1'b1, 1'b1, 5'd5, 64'h1234, 64'h8000_0000};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL b2b_first: got %h want %h", obs, exp);
    end
    tick();
    in_valid = 1'b0;
    exp = {1'b1, 1'b1, 1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0004};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL b2b_second: got %h want %h", obs, exp);
    end
    tick();
    // Pulses drop, index/data/pc hold.
    exp = {1'b1, 1'b0, 1'b0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0004};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL b2b_idle_hold: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_load_ext();
    logic [2:0]   f3  [8] = '{3'b000, 3'b100, 3'b001, 3'b110, 3'b011, 3'b010, 3'b101, 3'b111};
    logic [2:0]   off [8] = '{3'd7,   3'd7,   3'd6,   3'd4,   3'd0,   3'd1,   3'd3,   3'd5};
    logic [63:0]  res [8] = '{64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'hFFFF_FFFF_FFFF_8877,
                              64'h8877_6655, 64'h8877_6655_4433_2211, 64'h4433_2211,
                              64'h4433, 64'h0};
    logic [63:0]  pc;
    logic [135:0] exp;
    for (int i = 0; i < 8; i++) begin
      pc          = 64'h8000_1000 + 64'(i * 4);
      in_valid    = 1'b1;
      in_is_load  = 1'b1;
      in_rd_wen   = 1'b1;
      in_rd       = 5'd7;
      in_pc       = pc;
      in_funct3   = f3[i];
      in_addr_low = off[i];
      // A response in the accept cycle itself must be ignored.
      mem_rvalid  = 1'b1;
      mem_rdata   = 64'hDEAD_BEEF_CAFE_F00D;
      tick();
      in_valid   = 1'b0;
      in_is_load = 1'b0;
      mem_rvalid = 1'b0;
      vectors++;
      if (obs[135:133] !== 3'b000) begin
        miscompares++;
        $display("FAIL load%0d_wait1 ready/wen/ret: got %b want 000", i, obs[135:133]);
      end
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 64'h8877_6655_4433_2211;
      vectors++;
      if (obs[135:133] !== 3'b000) begin
        miscompares++;
        $display("FAIL load%0d_wait2 ready/wen/ret: got %b want 000", i, obs[135:133]);
      end
      tick();
      mem_rvalid = 1'b0;
      exp = {1'b1, 1'b1, 1'b1, 5'd7, res[i], pc};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL load%0d_f3_%b_off%0d: got %h want %h", i, f3[i], off[i], obs, exp);
      end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_x0();
    logic [135:0] exp;
    in_valid  = 1'b1;
    in_rd_wen = 1'b1;
    in_rd     = 5'd0;
    in_pc     = 64'h8000_2000;
    in_result = 64'hDEAD;
    tick();
    in_valid = 1'b0;
    exp = {1'b1, 1'b0, 1'b1, 5'd0, 64'hDEAD, 64'h8000_2000};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL x0_alu: got %h want %h", obs, exp);
    end
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_funct3  = 3'b011;
    in_pc      = 64'h8000_2004;
    tick();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222_3333_4444;
    tick();
    mem_rvalid = 1'b0;
    exp = {1'b1, 1'b0, 1'b1, 5'd0, 64'h1111_2222_3333_4444, 64'h8000_2004};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL x0_load: got %h want %h", obs, exp);
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_stall();
    logic [135:0] exp;
    // Stray response while idle.
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h5555_5555_5555_5555;
    tick();
    mem_rvalid = 1'b0;
    vectors++;
    if (obs[135:133] !== 3'b100) begin
      miscompares++;
      $display("FAIL stray_rvalid ready/wen/ret: got %b want 100", obs[135:133]);
    end
    // Load with in_valid held high throughout the stall.
    in_valid   = 1'b1;
    in_is_load = 1'b1;
    in_rd_wen  = 1'b1;
    in_rd      = 5'd9;
    in_funct3  = 3'b011;
    in_pc      = 64'h8000_3000;
    tick();
    for (int c = 1; c <= 10; c++) begin
      vectors++;
      if (obs[135:133] !== 3'b000) begin
        miscompares++;
        $display("FAIL stall_cycle%0d ready/wen/ret: got %b want 000", c, obs[135:133]);
      end
      if (c == 10) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0123_4567_89AB_CDEF;
      end else begin
        tick();
      end
    end
    tick();
    mem_rvalid = 1'b0;
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    exp = {1'b1, 1'b1, 1'b1, 5'd9, 64'h0123_4567_89AB_CDEF, 64'h8000_3000};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL stall_write: got %h want %h", obs, exp);
    end
    tick();
    exp = {1'b1, 1'b0, 1'b0, 5'd9, 64'h0123_4567_89AB_CDEF, 64'h8000_3000};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL stall_single_write: got %h want %h", obs, exp);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_load();
    logic [135:0] exp;
    in_valid    = 1'b1;
    in_is_load  = 1'b1;
    in_rd_wen   = 1'b1;
    in_rd       = 5'd3;
    in_funct3   = 3'b010;
    in_addr_low = 3'd0;
    in_pc       = 64'h8000_4000;
    tick();
    clear_inputs();
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_wait in_ready: got %b want 0", in_ready);
    end
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h7777_7777_7777_7777;
    tick();
    mem_rvalid = 1'b0;
    exp = {1'b1, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL midrst_late_rvalid: got %h want %h", obs, exp);
    end
    tick();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL midrst_after: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    test_reset();
    test_back_to_back();
    test_load_ext();
    test_x0();
    test_stall();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
